// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle for bin2bcd_seq. Optional 7-segment outputs
// appear only when BIN2BCD_SEG7_EN is defined.
interface bin2bcd_seq_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic [3:0]       dezena;
    logic [3:0]       unidade;
`ifdef BIN2BCD_SEG7_EN
    logic [6:0]       seg_dez;
    logic [6:0]       seg_uni;
`endif

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  dezena,
        input  unidade
`ifdef BIN2BCD_SEG7_EN
        ,
        input  seg_dez,
        input  seg_uni
`endif
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output dezena,
        output unidade
`ifdef BIN2BCD_SEG7_EN
        ,
        output seg_dez,
        output seg_uni
`endif
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one shift per clock.
// Define BIN2BCD_SEG7_EN to add registered active-low 7-segment outputs.
module bin2bcd_seq #(
    parameter int WIDTH = 6
) (
    input  logic           clk,
    input  logic           clr,
    bin2bcd_seq_if.slave   bus,
    output logic           dbg_state
);
    // Handshake: start is taken only on an edge where busy=0 (IDLE); bin is
    // captured on that edge. busy stays high for WIDTH cycles, then done
    // pulses for one cycle with dezena/unidade already holding the result.
    // A start seen during busy is dropped, not queued.

    localparam int SW = WIDTH + 8;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [3:0]      dez_q, dez_d;
    logic [3:0]      uni_q, uni_d;
    logic [SW-1:0]   corr;
    logic [SW-1:0]   shifted;

    // Add-3 correction on both BCD nibbles, then the left shift.
    always_comb begin
        corr = shreg_q;
        if (shreg_q[WIDTH+3:WIDTH] >= 4'd5)
            corr[WIDTH+3:WIDTH] = shreg_q[WIDTH+3:WIDTH] + 4'd3;
        if (shreg_q[WIDTH+7:WIDTH+4] >= 4'd5)
            corr[WIDTH+7:WIDTH+4] = shreg_q[WIDTH+7:WIDTH+4] + 4'd3;
        shifted = corr << 1;
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        dez_d   = dez_q;
        uni_d   = uni_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shreg_d = {8'b0, bus.bin};
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = shifted;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    dez_d   = shifted[SW-1:SW-4];
                    uni_d   = shifted[SW-5:SW-8];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BIN2BCD_SEG7_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [6:0] seg_dez_q, seg_dez_d;
    logic [6:0] seg_uni_q, seg_uni_d;

    always_comb begin
        seg_dez_d = seg7(dez_d);
        seg_uni_d = seg7(uni_d);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            seg_dez_q <= 7'b1000000;
            seg_uni_q <= 7'b1000000;
        end else begin
            seg_dez_q <= seg_dez_d;
            seg_uni_q <= seg_uni_d;
        end
    end

    assign bus.seg_dez = seg_dez_q;
    assign bus.seg_uni = seg_uni_q;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dez_q   <= 4'd0;
            uni_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dez_q   <= dez_d;
            uni_q   <= uni_d;
        end
    end

    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = done_q;
    assign bus.dezena  = dez_q;
    assign bus.unidade = uni_q;
    assign dbg_state   = state_q;
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter (shift-and-add-3) downstream of the 6-bit synchronous down counter (contadorsd). It captures the counter value on a start request and produces tens and units BCD digits for the display stage. A start/busy/done handshake lets the control logic trigger one conversion per count step. It is one shift per clock, so area is small and latency is fixed.

Parameters:
WIDTH, 6, binary input width; legal range 4..6 (max value 63, so tens is always ≤6 and fits one digit)

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous, active-low reset
start  input  1  conversion request, sampled on rising clk
bin  input  WIDTH  binary value, sampled only when a start is accepted
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when dezena/unidade update
dezena  output  4  BCD tens digit, registered
unidade  output  4  BCD units digit, registered

Behaviour:
- Reset (clr=0, asynchronous, no clock needed): state=IDLE; busy=0, done=0, dezena=0, unidade=0; internal shift register and counter cleared.
- Reset release: first active edge is the first clk rise with clr=1.
- States:
  - IDLE: busy=0. On an edge with start=1, load shreg={8'b0, bin}, cnt=WIDTH, go to SHIFT.
  - SHIFT: busy=1. Each edge: (1) add 3 to each BCD nibble ≥5 (combinational correction); (2) shift the whole register left by 1; (3) decrement cnt.
  - Last SHIFT edge (cnt=1): write the corrected and shifted nibbles to dezena/unidade, set done=1, go to IDLE.
- done: high for exactly one cycle following the final shift edge; otherwise 0.
- Latency: start accepted at edge E0; busy=1 from E0 through E_WIDTH; done=1 and new digits valid after E_WIDTH, i.e. WIDTH cycles after acceptance. Throughput is one conversion per WIDTH cycles.
- start while busy=1: ignored, not queued.
- bin changes during SHIFT: ignored, because the value was captured at acceptance.
- start=1 in the same cycle as done=1 (state is IDLE): accepted; the next conversion begins immediately.
- dezena/unidade hold the last result until the next completion. They never show intermediate values.
- Reset mid-conversion: conversion aborted, all outputs forced to reset values, no done pulse.
- Boundary values: bin=0 → 0/0; bin=2^WIDTH-1 → correct BCD (63 → 6/3). No illegal BCD digit (>9) ever appears on the outputs.

Optional Feature:
Macro BIN2BCD_SEG7_EN.
- Defined:
  - Adds outputs seg_dez[6:0] and seg_uni[6:0], active-low 7-segment codes (bit order gfedcba, common anode).
  - They are registered on the same edge as dezena/unidade, so done also qualifies them.
  - Reset value 7'b1000000 (shows "0").
  - Codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Not defined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
1. Reset: drive clr=0 between clock edges during SHIFT → busy, done, dezena, unidade go to 0 immediately, without waiting for an edge. Release clr: block idles with outputs 0.
2. bin=63, start pulse 1 cycle → busy=1 for 6 cycles; done=1 exactly once after 6th edge; dezena=6, unidade=3.
3. Boundaries, run sequentially → bin=0 gives 0/0; bin=9 gives 0/9; bin=10 gives 1/0; bin=59 gives 5/9.
4. Handshake:
   - Start 63, then start=1 with bin=42 during busy → 42 ignored; result 6/3.
   - start=1 held through the done cycle with bin=42 → second conversion accepted back-to-back; result 4/2 six cycles later.
5. Reset mid-conversion: start bin=37, assert clr after 3 shifts → no done, outputs 0. Restart with bin=37 → 3/7.
6. Sweep: feed a 6-bit down counter 63→0 with start on each step; compare every result against bin/10 and bin%10. With BIN2BCD_SEG7_EN, bin=36 → seg_dez=0110000, seg_uni=0000010.
